// File: rtl/next_pc_ctrl.sv
// Next-PC selection for the PC register, with a circular return-address stack
// that services call/ret and reports sticky overflow/underflow.
module next_pc_ctrl #(
    parameter int unsigned PC_W      = 5,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned RAS_PTR_W = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [PC_W-1:0]      pc_cur,
    input  logic                 stall,
    input  logic                 branch_en,
    input  logic                 branch_taken,
    input  logic [PC_W-1:0]      branch_off,
    input  logic                 jump_en,
    input  logic                 call_en,
    input  logic                 ret_en,
    input  logic [PC_W-1:0]      jump_target,
    output logic [PC_W-1:0]      pc_next,
    output logic                 redirect,
    output logic [RAS_PTR_W:0]   ras_count,
    output logic                 ras_overflow,
    output logic                 ras_underflow
);

    localparam int unsigned CNT_W = RAS_PTR_W + 1;

    logic [PC_W-1:0]      ras_mem [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] wp;
    logic [RAS_PTR_W-1:0] top_idx;
    logic [PC_W-1:0]      seq;
    logic [PC_W-1:0]      ras_top;
    logic                 ras_empty;
    logic                 ras_full;
    logic                 do_push;
    logic                 do_pop;
    logic                 do_underflow;

    assign seq       = pc_cur + PC_W'(1);
    assign top_idx   = wp - RAS_PTR_W'(1);
    assign ras_top   = ras_mem[top_idx];
    assign ras_empty = (ras_count == CNT_W'(0));
    assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));

    // Priority resolution; only the winning request may touch the RAS.
    always_comb begin
        pc_next      = seq;
        do_push      = 1'b0;
        do_pop       = 1'b0;
        do_underflow = 1'b0;
        if (stall) begin
            pc_next = pc_cur;
        end else if (ret_en) begin
            if (!ras_empty) begin
                pc_next = ras_top;
                do_pop  = 1'b1;
            end else begin
                do_underflow = 1'b1;
            end
        end else if (call_en) begin
            pc_next = jump_target;
            do_push = 1'b1;
        end else if (jump_en) begin
            pc_next = jump_target;
        end else if (branch_en && branch_taken) begin
            pc_next = seq + branch_off;
        end
    end

    assign redirect = !stall && (pc_next != seq);

    // RAS storage, pointer, occupancy and sticky flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp            <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                ras_mem[wp] <= seq;
                wp          <= wp + RAS_PTR_W'(1);
                if (ras_full) begin
                    ras_overflow <= 1'b1;
                end else begin
                    ras_count <= ras_count + CNT_W'(1);
                end
            end
            if (do_pop) begin
                wp        <= wp - RAS_PTR_W'(1);
                ras_count <= ras_count - CNT_W'(1);
            end
            if (do_underflow) begin
                ras_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Bench for next_pc_ctrl: directed scenarios plus randomized traffic against a
// queue-based return-stack model.
module tb_next_pc_ctrl;

    localparam int DEPTH = 4;
    localparam int MODV  = 32;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] pc_cur;
    logic       stall;
    logic       branch_en;
    logic       branch_taken;
    logic [4:0] branch_off;
    logic       jump_en;
    logic       call_en;
    logic       ret_en;
    logic [4:0] jump_target;
    logic [4:0] pc_next;
    logic       redirect;
    logic [2:0] ras_count;
    logic       ras_overflow;
    logic       ras_underflow;

    int checks = 0;
    int errors = 0;

    int ras_q[$];
    bit m_ovf;
    bit m_unf;

    next_pc_ctrl #(.PC_W(5), .RAS_DEPTH(4), .RAS_PTR_W(2)) dut (
        .clock(clock), .reset(reset), .pc_cur(pc_cur), .stall(stall),
        .branch_en(branch_en), .branch_taken(branch_taken), .branch_off(branch_off),
        .jump_en(jump_en), .call_en(call_en), .ret_en(ret_en),
        .jump_target(jump_target), .pc_next(pc_next), .redirect(redirect),
        .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clock = ~clock;

    function automatic int exp_next();
        int seqv = (int'(pc_cur) + 1) % MODV;
        if (stall) return int'(pc_cur);
        if (ret_en) return (ras_q.size() > 0) ? ras_q[$] : seqv;
        if (call_en || jump_en) return int'(jump_target);
        if (branch_en && branch_taken) return (seqv + int'(branch_off)) % MODV;
        return seqv;
    endfunction

    function automatic bit exp_redirect();
        return !stall && (exp_next() != (int'(pc_cur) + 1) % MODV);
    endfunction

    function automatic void model_update();
        if (stall) return;
        if (ret_en) begin
            if (ras_q.size() > 0) void'(ras_q.pop_back());
            else m_unf = 1'b1;
        end else if (call_en) begin
            if (ras_q.size() == DEPTH) begin
                void'(ras_q.pop_front());
                m_ovf = 1'b1;
            end
            ras_q.push_back((int'(pc_cur) + 1) % MODV);
        end
    endfunction

    function automatic void model_clear();
        ras_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    task automatic idle();
        stall = 0; branch_en = 0; branch_taken = 0; branch_off = '0;
        jump_en = 0; call_en = 0; ret_en = 0; jump_target = '0;
    endtask

    task automatic tick();
        if (!reset) model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        pc_cur = '0;
        reset = 1'b1;
        model_clear();
        @(posedge clock);
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle();
        pc_cur = 5'd0;
        reset = 1'b1;
        model_clear();
        #3;
        checks++;
        if (ras_count !== 3'd0 || ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state count=%0d ovf=%0b unf=%0b required 0/0/0", ras_count, ras_overflow, ras_underflow);
        end
        checks++;
        if (pc_next !== 5'd1) begin
            errors++;
            $display("FAIL reset_pc_next got %0d required 1", pc_next);
        end
        @(posedge clock);
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 32; i++) begin
            pc_cur = 5'(i);
            #1;
            checks++;
            if (pc_next !== 5'((i + 1) % 32) || redirect !== 1'b0) begin
                errors++;
                $display("FAIL seq_pc pc_cur=%0d got %0d/%0b required %0d/0", i, pc_next, redirect, (i + 1) % 32);
            end
            tick();
            checks++;
            if (ras_count !== 3'd0) begin
                errors++;
                $display("FAIL seq_count got %0d required 0", ras_count);
            end
        end
    endtask

    task automatic test_branch();
        idle();
        pc_cur = 5'd10; branch_en = 1; branch_taken = 1; branch_off = 5'b11101;
        #1;
        checks++;
        if (pc_next !== 5'd8 || redirect !== 1'b1) begin
            errors++;
            $display("FAIL branch_taken got %0d/%0b required 8/1", pc_next, redirect);
        end
        branch_taken = 0;
        #1;
        checks++;
        if (pc_next !== 5'd11 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL branch_not_taken got %0d/%0b required 11/0", pc_next, redirect);
        end
        branch_taken = 1; branch_off = 5'd0;
        #1;
        checks++;
        if (pc_next !== 5'd11 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL branch_off0 got %0d/%0b required 11/0", pc_next, redirect);
        end
        pc_cur = 5'd30; branch_off = 5'd3;
        #1;
        checks++;
        if (pc_next !== 5'd2 || redirect !== 1'b1) begin
            errors++;
            $display("FAIL branch_wrap got %0d/%0b required 2/1", pc_next, redirect);
        end
        tick();
        idle();
    endtask

    task automatic test_call_ret();
        do_reset();
        pc_cur = 5'd4; call_en = 1; jump_target = 5'd20;
        #1;
        checks++;
        if (pc_next !== 5'd20 || redirect !== 1'b1) begin
            errors++;
            $display("FAIL call_pc got %0d/%0b required 20/1", pc_next, redirect);
        end
        tick();
        checks++;
        if (ras_count !== 3'd1) begin
            errors++;
            $display("FAIL call_count got %0d required 1", ras_count);
        end
        idle();
        pc_cur = 5'd20; ret_en = 1;
        #1;
        checks++;
        if (pc_next !== 5'd5 || redirect !== 1'b1) begin
            errors++;
            $display("FAIL ret_pc got %0d/%0b required 5/1", pc_next, redirect);
        end
        tick();
        checks++;
        if (ras_count !== 3'd0 || ras_underflow !== 1'b0) begin
            errors++;
            $display("FAIL ret_count got %0d/%0b required 0/0", ras_count, ras_underflow);
        end
        idle();
    endtask

    task automatic test_overflow();
        int rets[4] = '{6, 5, 4, 3};
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            idle();
            pc_cur = 5'(i); call_en = 1; jump_target = 5'd25;
            tick();
        end
        checks++;
        if (ras_count !== 3'd4 || ras_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_state got %0d/%0b required 4/1", ras_count, ras_overflow);
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            pc_cur = 5'd25; ret_en = 1;
            #1;
            checks++;
            if (pc_next !== 5'(rets[i])) begin
                errors++;
                $display("FAIL ovf_ret%0d got %0d required %0d", i, pc_next, rets[i]);
            end
            tick();
        end
        pc_cur = 5'd17;
        #1;
        checks++;
        if (pc_next !== 5'd18 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL unf_pc got %0d/%0b required 18/0", pc_next, redirect);
        end
        tick();
        checks++;
        if (ras_underflow !== 1'b1 || ras_count !== 3'd0 || ras_overflow !== 1'b1) begin
            errors++;
            $display("FAIL unf_state unf=%0b cnt=%0d ovf=%0b required 1/0/1", ras_underflow, ras_count, ras_overflow);
        end
        idle();
    endtask

    task automatic test_priority_stall();
        do_reset();
        pc_cur = 5'd7; stall = 1; call_en = 1; jump_target = 5'd3;
        #1;
        checks++;
        if (pc_next !== 5'd7 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL stall_pc got %0d/%0b required 7/0", pc_next, redirect);
        end
        tick();
        checks++;
        if (ras_count !== 3'd0) begin
            errors++;
            $display("FAIL stall_count got %0d required 0", ras_count);
        end
        idle();
        pc_cur = 5'd11; call_en = 1; jump_target = 5'd2;
        tick();
        idle();
        pc_cur = 5'd2; call_en = 1; ret_en = 1; jump_target = 5'd20;
        #1;
        checks++;
        if (pc_next !== 5'd12 || redirect !== 1'b1) begin
            errors++;
            $display("FAIL callret_pc got %0d/%0b required 12/1", pc_next, redirect);
        end
        tick();
        checks++;
        if (ras_count !== 3'd0 || ras_overflow !== 1'b0) begin
            errors++;
            $display("FAIL callret_count got %0d/%0b required 0/0", ras_count, ras_overflow);
        end
        idle();
        pc_cur = 5'd9; jump_en = 1; branch_en = 1; branch_taken = 1; branch_off = 5'd4; jump_target = 5'd1;
        #1;
        checks++;
        if (pc_next !== 5'd1) begin
            errors++;
            $display("FAIL jump_over_branch got %0d required 1", pc_next);
        end
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle();
            pc_cur = 5'(i + 8); call_en = 1; jump_target = 5'd0;
            tick();
        end
        idle();
        pc_cur = 5'd0; ret_en = 1;
        tick();
        checks++;
        if (ras_count !== 3'd3 || ras_overflow !== 1'b1) begin
            errors++;
            $display("FAIL premid_state got %0d/%0b required 3/1", ras_count, ras_overflow);
        end
        ret_en = 1;
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        checks++;
        if (ras_count !== 3'd0 || ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset cnt=%0d ovf=%0b unf=%0b required 0/0/0", ras_count, ras_overflow, ras_underflow);
        end
        @(posedge clock);
        #2;
        idle();
        reset = 1'b0;
        @(posedge clock);
        #1;
        pc_cur = 5'd3; ret_en = 1;
        #1;
        checks++;
        if (pc_next !== 5'd4) begin
            errors++;
            $display("FAIL post_reset_ret got %0d required 4", pc_next);
        end
        tick();
        idle();
    endtask

    task automatic test_random();
        int e;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            stall        = ($urandom % 8) == 0;
            ret_en       = ($urandom % 4) == 0;
            call_en      = ($urandom % 3) == 0;
            jump_en      = ($urandom % 6) == 0;
            branch_en    = ($urandom % 3) == 0;
            branch_taken = $urandom % 2;
            branch_off   = 5'($urandom);
            jump_target  = 5'($urandom);
            pc_cur       = 5'($urandom);
            #1;
            e = exp_next();
            checks++;
            if (pc_next !== 5'(e) || redirect !== exp_redirect()) begin
                errors++;
                $display("FAIL rand_pc n=%0d got %0d/%0b required %0d/%0b", n, pc_next, redirect, e, exp_redirect());
            end
            tick();
            checks++;
            if (ras_count !== 3'(ras_q.size()) || ras_overflow !== m_ovf || ras_underflow !== m_unf) begin
                errors++;
                $display("FAIL rand_state n=%0d got %0d/%0b/%0b required %0d/%0b/%0b", n,
                         ras_count, ras_overflow, ras_underflow, ras_q.size(), m_ovf, m_unf);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        pc_cur = '0;
        reset = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_call_ret();
        test_overflow();
        test_priority_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/next_pc_ctrl.md
# next_pc_ctrl

Next-PC generator feeding the 5-bit PC register. Each cycle it takes the current PC and the control-flow request from decode (sequential, branch, jump, call, return, stall) and drives the PC register's input with the address to load at the next rising clock edge. It holds a small circular return-address stack (RAS) so that `call`/`ret` work without a data-memory stack. Sticky flags report RAS overflow and underflow.

## Interface
- `PC_W`, default 5: PC width. Addresses wrap modulo 2^PC_W.
- `RAS_DEPTH`, default 4: number of RAS entries. Must be a power of 2.
- `RAS_PTR_W`, default 2: log2(`RAS_DEPTH`).

- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high.
- `pc_cur`  in  PC_W: current PC, taken from the PC register output.
- `stall`  in  1: hold the PC; no RAS change.
- `branch_en`  in  1: conditional branch instruction.
- `branch_taken`  in  1: branch condition result; only meaningful with `branch_en`.
- `branch_off`  in  PC_W: two's-complement offset, relative to PC+1.
- `jump_en`  in  1: absolute jump to `jump_target`.
- `call_en`  in  1: push PC+1, then jump to `jump_target`.
- `ret_en`  in  1: pop the RAS top and jump to it.
- `jump_target`  in  PC_W: absolute target for jump and call.
- `pc_next`  out  PC_W: next PC, wired to the PC register input.
- `redirect`  out  1: `pc_next` differs from sequential PC+1 and there is no stall. Used as the pipeline flush request.
- `ras_count`  out  RAS_PTR_W+1: number of valid entries (0..RAS_DEPTH).
- `ras_overflow`  out  1: sticky; a push was made while the RAS was full.
- `ras_underflow`  out  1: sticky; a pop was attempted while the RAS was empty.

## Operation
- `seq` = `pc_cur` + 1, truncated to PC_W (so 31 -> 0).
- `pc_next` is combinational. Requests are resolved in this priority order:
  - `stall` -> `pc_cur`.
  - `ret_en`:
    - If `ras_count` > 0: top entry.
    - If empty: `seq`, and set `ras_underflow`.
  - `call_en` -> `jump_target`; push `seq`.
  - `jump_en` -> `jump_target`.
  - `branch_en` and `branch_taken` -> `seq` + `branch_off`, mod 2^PC_W.
  - Otherwise -> `seq`.
- Lower-priority requests asserted in the same cycle are ignored entirely, including any RAS side effects. Example: `call_en` together with `ret_en` gives pop only, no push.
- RAS structure:
  - Array of `RAS_DEPTH` x PC_W entries.
  - Write pointer `wp`; the top entry is at `wp`-1 (mod depth).
  - A 3-bit count for the default depth.
- Push (at clock edge):
  - Write `seq` into entry `wp`, then `wp`+1.
  - `ras_count` increments, saturating at `RAS_DEPTH`.
  - If the RAS was already full, the oldest entry is overwritten (circular) and `ras_overflow` is set.
- Pop (at clock edge, count > 0): `wp`-1 and `ras_count`-1.
- Flags stay at 1 until `reset`.
- `redirect` = !`stall` && (`pc_next` != `seq`).
  - A taken branch with offset 0 gives `redirect` = 0.
  - A ret on an empty RAS gives `redirect` = 0.

## Timing
- `pc_next` and `redirect` follow same-cycle inputs with zero latency. The PC register captures `pc_next` on the next rising edge.
- RAS pointer, entries, count and flags update on the rising edge of `clock`.
- A `call` in cycle N followed by `ret` in cycle N+1 returns the value pushed in cycle N.
- Reset (asynchronous, at any time, including mid call/ret sequence):
  - `wp`=0, `ras_count`=0, all entries 0, `ras_overflow`=0, `ras_underflow`=0.
  - Any push or pop in flight is discarded.
- `pc_next` and `redirect` are not registered. While `reset` is high they still follow the inputs; the PC register is held at 0 by its own reset.
- During `stall`, no state changes regardless of the other request inputs.

## Test plan
- Reset, `pc_cur`=0, no requests, incrementing `pc_cur` -> `pc_next`=1,2,…,31,0 (wrap). `redirect`=0 throughout. `ras_count`=0.
- `pc_cur`=10, `branch_en`=1:
  - `branch_taken`=1, `branch_off`=5'b11101 (-3) -> `pc_next`=8, `redirect`=1.
  - `branch_taken`=0 -> `pc_next`=11, `redirect`=0.
- Call/return sequence:
  - `pc_cur`=4, `call_en`=1, `jump_target`=20 -> `pc_next`=20. After the edge, `ras_count`=1.
  - Next cycle, `pc_cur`=20, `ret_en`=1 -> `pc_next`=5. After the edge, `ras_count`=0.
- Overflow: five calls from PCs 1, 2, 3, 4, 5.
  - After them, `ras_count`=4 and `ras_overflow`=1.
  - Four rets return 6, 5, 4, 3.
  - A fifth ret gives `pc_next`=`pc_cur`+1 and sets `ras_underflow`=1.
- Priority and stall:
  - `stall`=1 with `call_en`=1, `pc_cur`=7 -> `pc_next`=7, `redirect`=0, no RAS change.
  - `call_en`=1 with `ret_en`=1 and RAS top=12 -> `pc_next`=12, count decrements, no push.
- Reset asserted mid-sequence with `ras_count`=3 and `ras_overflow`=1 -> count=0 and both flags 0 immediately, without waiting for a clock edge.
